muldiv_unit: RTL

- Parametrised iterative multiply/divide unit; the next-generation companion to the single-cycle ALU, implementing the RV32M operations.
- Sits beside the ALU in the execute stage. The pipeline stalls on in_ready/out_valid.
- XLEN-generic, with valid/ready handshakes on both sides and a multi-cycle shift-add / restoring-divide datapath.
- Status flags use the ALU's naming and meaning.

---
 rtl/muldiv_unit.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide unit with valid/ready
// handshakes on both sides. Multiplies use a radix-2 shift-add datapath and
// divides use restoring division; both share one 2*XLEN accumulator.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle combinational
// multiply for MUL/MULH/MULHSU/MULHU; divide is unaffected).
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in_1,
  input  logic [XLEN-1:0] in_2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            zero,
  output logic            sign,
  output logic            div_zero,
  output logic            overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [XLEN-1:0]     out_q, out_d;
  logic                div_zero_q, div_zero_d;
  logic                overflow_q, overflow_d;

  // Request decode
  logic                signed_a, signed_b;
  logic                neg_a, neg_b;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                res_neg;
  logic                b_zero;
  logic                sgn_ovf;

  // Iteration datapath
  logic [XLEN-1:0]     acc_hi, acc_lo;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       div_shl;
  logic [XLEN:0]       div_diff;
  logic [2*XLEN-1:0]   div_next;
  logic [2*XLEN-1:0]   step_next;
  logic [2*XLEN-1:0]   prod_signed;
  logic [XLEN-1:0]     div_val;
  logic [XLEN-1:0]     div_res;
  logic [XLEN-1:0]     final_res;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0]   fast_prod;
  logic [2*XLEN-1:0]   fast_signed;
  logic [XLEN-1:0]     fast_res;
`endif

  // Decode the incoming request into operand magnitudes and result sign
  always_comb begin
    signed_a = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
    signed_b = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    neg_a    = signed_a & in_1[XLEN-1];
    neg_b    = signed_b & in_2[XLEN-1];
    a_mag    = neg_a ? ('0 - in_1) : in_1;
    b_mag    = neg_b ? ('0 - in_2) : in_2;
    // Remainder takes the dividend sign; every other op takes the XOR.
    res_neg  = (op[2] & op[1]) ? neg_a : (neg_a ^ neg_b);
    b_zero   = (in_2 == '0);
    sgn_ovf  = ((op == 3'b100) || (op == 3'b110)) && (in_1 == MIN_NEG) && (in_2 == '1);
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    acc_hi   = acc_q[2*XLEN-1:XLEN];
    acc_lo   = acc_q[XLEN-1:0];
    // Multiply: {hi,lo} holds partial product over the remaining multiplier bits.
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_lo[XLEN-1:1]};
    // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
    div_shl  = {acc_hi, acc_lo[XLEN-1]};
    div_diff = div_shl - {1'b0, b_q};
    if (!div_diff[XLEN]) begin
      div_next = {div_diff[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};
    end else begin
      div_next = {div_shl[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0};
    end
    step_next   = op_q[2] ? div_next : mul_next;
    prod_signed = neg_q ? ('0 - step_next) : step_next;
    div_val     = op_q[1] ? step_next[2*XLEN-1:XLEN] : step_next[XLEN-1:0];
    div_res     = neg_q ? ('0 - div_val) : div_val;
    if (op_q[2]) begin
      final_res = div_res;
    end else if (op_q[1:0] == 2'b00) begin
      final_res = prod_signed[XLEN-1:0];
    end else begin
      final_res = prod_signed[2*XLEN-1:XLEN];
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle magnitude multiply with sign fix-up
  always_comb begin
    fast_prod   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    fast_signed = res_neg ? ('0 - fast_prod) : fast_prod;
    fast_res    = (op[1:0] == 2'b00) ? fast_signed[XLEN-1:0] : fast_signed[2*XLEN-1:XLEN];
  end
`endif

  // Next-state and handshake outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_d      = neg_q;
    acc_d      = acc_q;
    b_d        = b_q;
    out_d      = out_q;
    div_zero_d = div_zero_q;
    overflow_d = overflow_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready   = 1'b1;
        out_d      = '0;
        div_zero_d = 1'b0;
        overflow_d = 1'b0;
        if (in_valid) begin
          op_d  = op;
          neg_d = res_neg;
          b_d   = b_mag;
          acc_d = {{XLEN{1'b0}}, a_mag};
          cnt_d = CNT_W'(XLEN);
          if (op[2] && b_zero) begin
            state_d    = S_DONE;
            cnt_d      = '0;
            out_d      = op[1] ? in_1 : '1;
            div_zero_d = 1'b1;
          end else if (sgn_ovf) begin
            state_d    = S_DONE;
            cnt_d      = '0;
            out_d      = op[1] ? '0 : in_1;
            overflow_d = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!op[2]) begin
            state_d = S_DONE;
            cnt_d   = '0;
            out_d   = fast_res;
`endif
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step_next;
        cnt_d = cnt_q - 1'b1;
        // The last step's result is finalised in the same cycle it is formed.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          out_d   = final_res;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          out_d      = '0;
          div_zero_d = 1'b0;
          overflow_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      acc_q      <= '0;
      b_q        <= '0;
      out_q      <= '0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      out_q      <= out_d;
      div_zero_q <= div_zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign out      = out_q;
  assign zero     = (out_q == '0);
  assign sign     = out_q[XLEN-1];
  assign div_zero = div_zero_q;
  assign overflow = overflow_q;

endmodule
